// File: rtl/memory_stage_pkg.sv
// Shared types for the memory stage: bus types in package common,
// pipeline records and the FSM state enum in package pipes.
package common;
    typedef logic [63:0] word_t;
    typedef logic [63:0] addr_t;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;
endpackage

package pipes;
    import common::*;

    typedef logic [4:0] creg_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        memread;
        logic        memwrite;
        word_t       writedata;
        word_t       aluout;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        creg_addr_t  dst;
        msize_t      msize;
        logic        mem_unsigned;
    } execute_data_t;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        word_t       result;
        logic [63:0] pc;
        logic [31:0] raw_instr;
        creg_addr_t  dst;
        logic        misalign;
    } memory_data_t;
endpackage

// File: rtl/memory_stage_memalign.sv
// memalign: combinational lane steering for the data bus.
// Builds store strobe/data from the low address bits and extends load data.
module memalign
    import common::*;
(
    input  logic [2:0] i_offset,
    input  msize_t     i_size,
    input  logic       i_store,
    input  logic       i_unsigned,
    input  word_t      i_wdata,
    input  word_t      i_rdata,
    output strobe_t    o_strobe,
    output word_t      o_wdata,
    output word_t      o_ldata
);
    logic [5:0] w_shamt;
    strobe_t    w_mask;
    word_t      w_shifted;

    assign w_shamt = {i_offset, 3'b000};

    // store side: byte-enable mask by size, moved into the addressed lanes
    always_comb begin
        case (i_size)
            MSIZE1:  w_mask = 8'h01;
            MSIZE2:  w_mask = 8'h03;
            MSIZE4:  w_mask = 8'h0F;
            default: w_mask = 8'hFF;
        endcase
        o_strobe = i_store ? (w_mask << i_offset) : '0;
        o_wdata  = i_wdata << w_shamt;
    end

    // load side: bring addressed bytes to lane 0, truncate, then extend
    always_comb begin
        w_shifted = i_rdata >> w_shamt;
        case (i_size)
            MSIZE1:  o_ldata = i_unsigned ? {56'b0, w_shifted[7:0]}
                                          : {{56{w_shifted[7]}}, w_shifted[7:0]};
            MSIZE2:  o_ldata = i_unsigned ? {48'b0, w_shifted[15:0]}
                                          : {{48{w_shifted[15]}}, w_shifted[15:0]};
            MSIZE4:  o_ldata = i_unsigned ? {32'b0, w_shifted[31:0]}
                                          : {{32{w_shifted[31]}}, w_shifted[31:0]};
            default: o_ldata = w_shifted;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: issues loads/stores on the data bus, stalls until data_ok,
// and holds the captured load result while the downstream stage is stalled.
// Optional feature macro: MEM_MISALIGN_CHECK_EN (suppresses misaligned accesses
// and flags them on dataM.misalign).
module memory_stage
    import common::*;
    import pipes::*;
(
    input  logic          clk,
    input  logic          reset,
    input  execute_data_t dataE,
    output memory_data_t  dataM,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp,
    input  logic          stallM,
    output logic          memstall,
    output word_t         memdata
);
    mem_state_t r_state;
    mem_state_t w_next;
    word_t      r_data;
    logic       w_misalign;
    logic       w_memop;
    strobe_t    w_strobe;
    word_t      w_wdata;
    word_t      w_ldata;
    word_t      w_load;
    dbus_req_t  w_req;
    logic       w_unused_addr_ok;

    // Completion keys on data_ok alone; address acceptance carries no extra meaning here.
    assign w_unused_addr_ok = dresp.addr_ok;

`ifdef MEM_MISALIGN_CHECK_EN
    // flag a memory op whose address is not a multiple of its access size
    always_comb begin
        w_misalign = 1'b0;
        if (dataE.valid && (dataE.memread || dataE.memwrite)) begin
            case (dataE.msize)
                MSIZE2:  w_misalign = dataE.aluout[0];
                MSIZE4:  w_misalign = |dataE.aluout[1:0];
                MSIZE8:  w_misalign = |dataE.aluout[2:0];
                default: w_misalign = 1'b0;
            endcase
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_memop = dataE.valid & (dataE.memread | dataE.memwrite) & ~w_misalign;

    memalign u_memalign (
        .i_offset   (dataE.aluout[2:0]),
        .i_size     (dataE.msize),
        .i_store    (dataE.memwrite),
        .i_unsigned (dataE.mem_unsigned),
        .i_wdata    (dataE.writedata),
        .i_rdata    (dresp.data),
        .o_strobe   (w_strobe),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    // request fields come straight from dataE, which memstall keeps frozen while waiting
    always_comb begin
        w_req.valid  = 1'b1;
        w_req.addr   = dataE.aluout;
        w_req.size   = dataE.msize;
        w_req.strobe = w_strobe;
        w_req.data   = w_wdata;
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_memop) w_next = dresp.data_ok ? (stallM ? HOLD : IDLE) : WAIT;
            WAIT: if (dresp.data_ok) w_next = stallM ? HOLD : IDLE;
            HOLD: if (!stallM) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // outputs: bus request, stall and the load value seen by writeback/forwarding
    always_comb begin
        dreq     = '0;
        memstall = 1'b0;
        w_load   = w_ldata;
        case (r_state)
            IDLE: if (w_memop) begin
                dreq     = w_req;
                memstall = ~dresp.data_ok;
            end
            WAIT: begin
                dreq     = w_req;
                memstall = ~dresp.data_ok;
            end
            HOLD: w_load = r_data;
            default: ;
        endcase
        // reset drops the request immediately, before any clock edge
        if (reset) begin
            dreq.valid = 1'b0;
            memstall   = 1'b0;
        end
    end

    // capture the extended load data on completion so HOLD can replay it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
        end else if (dresp.data_ok && ((r_state == IDLE && w_memop) || r_state == WAIT)) begin
            r_data <= w_ldata;
        end
    end

    // writeback record and forwarding value
    always_comb begin
        dataM.valid     = dataE.valid & ~memstall;
        dataM.regwrite  = dataE.regwrite & ~w_misalign;
        dataM.memtoreg  = dataE.memtoreg;
        dataM.result    = dataE.memtoreg ? w_load : dataE.aluout;
        dataM.pc        = dataE.pc;
        dataM.raw_instr = dataE.raw_instr;
        dataM.dst       = dataE.dst;
        dataM.misalign  = w_misalign;
    end

    assign memdata = w_load;
endmodule
